fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage controller that owns the program counter and sequences instruction-bus transactions for the pipeline front end. It issues one ibus request per PC and holds the returned instruction for the fetch/decode register until downstream accepts it. It services redirects (branch/jump/exception) from later stages, including redirects that arrive while a bus transaction is outstanding. It sits between the ibus port and the F/D pipeline register and replaces the free-running PC update path.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- ibus_req  out  1  instruction fetch request valid.
- ibus_addr  out  64  fetch address; held stable while ibus_req=1 and no ibus_data_ok.
- ibus_data_ok  in  1  response valid; completes the outstanding request this cycle.
- ibus_data  in  32  instruction word, valid with ibus_data_ok.
- redirect_valid  in  1  later stage demands fetch restart.
- redirect_pc  in  64  restart target.
- stall  in  1  downstream cannot accept inst this cycle.
- inst_valid  out  1  inst/inst_pc valid to F/D register.
- inst  out  32  fetched instruction.
- inst_pc  out  64  PC of inst.
- inst_fault  out  1  misaligned-fetch fault tag; see Configuration.

## Operation
- States: REQ (request asserted for pc), HOLD (instruction captured, offered downstream), DRAIN (discarding an in-flight response after redirect). Plus pend_pc register.
- REQ: ibus_req=1, ibus_addr=pc. On ibus_data_ok: capture ibus_data into inst, pc into inst_pc, go HOLD.
- HOLD: inst_valid=1, ibus_req=0. If stall=0: pc <= pc+4 (64-bit wrap, no carry-out), go REQ. If stall=1: stay, outputs unchanged.
- Redirect has priority over every other event:
  - REQ with ibus_data_ok same cycle: data discarded, pc <= redirect_pc, stay REQ.
  - REQ without ibus_data_ok: bus request must not be withdrawn; pend_pc <= redirect_pc, go DRAIN.
  - DRAIN: ibus_req=1, ibus_addr unchanged; a further redirect overwrites pend_pc; on ibus_data_ok data discarded, pc <= pend_pc (or redirect_pc if redirect same cycle), go REQ.
  - HOLD: instruction dropped regardless of stall, pc <= redirect_pc, go REQ.
- inst_valid is never asserted in REQ or DRAIN.

## Timing
- Reset (asynchronous assert): state=REQ, pc=RESET_PC, pend_pc=0, inst=0, inst_pc=0, inst_valid=0, inst_fault=0. ibus_req=1 with ibus_addr=RESET_PC in first cycle after reset deasserts.
- Reset asserted mid-transaction: everything returns to reset values immediately; any later ibus_data_ok for the aborted request is the bus's responsibility (not tracked).
- Response in cycle N -> inst_valid=1 in cycle N+1 (registered).
- HOLD with stall=0 in cycle N -> ibus_req=1 at pc+4 in cycle N+1.
- Zero-wait bus: ibus_data_ok in the same cycle as the request is legal; peak throughput one instruction per 2 cycles.
- Redirect in cycle N (not DRAIN-bound) -> ibus_addr=redirect_pc in cycle N+1.

## Configuration
- FETCH_MISALIGN_CHK_EN defined: when pc[1:0]!=0 in REQ, no bus request is issued (ibus_req=0); next cycle enters HOLD with inst=32'h0000_0013, inst_pc=pc, inst_fault=1. Fault clears when leaving HOLD. Redirects behave as in HOLD.
- Not defined: no check; misaligned pc is driven on ibus_addr unchanged; inst_fault tied 0.

## Test plan
- Reset release, bus responds in 0 cycles with 32'h0000_0093 -> ibus_addr 0x8000_0000, inst_valid next cycle, inst_pc 0x8000_0000; then request at 0x8000_0004.
- stall=1 for 3 cycles in HOLD -> inst/inst_pc stable, ibus_req=0; stall drops -> request at pc+4 next cycle.
- Bus with 3-cycle latency, redirect to 0x8000_0100 one cycle after request -> ibus_addr held, response discarded (no inst_valid), next request 0x8000_0100.
- Two redirects (0x100, then 0x200) during DRAIN -> only 0x8000_0200 fetched; simultaneous redirect+data_ok in REQ -> data dropped, next addr = redirect_pc.
- Redirect during HOLD with stall=1 -> inst_valid=0 next cycle, request at redirect_pc.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x8000_0102 -> ibus_req stays 0, inst_valid=1 with inst_fault=1, inst_pc 0x8000_0102; without macro -> ibus_addr 0x8000_0102, inst_fault=0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-controller port bundle: instruction bus, redirect/stall inputs from the
// pipeline and the F/D register outputs. The controller uses the master modport.
interface fetch_ctrl_if;
    logic        ibus_req;
    logic [63:0] ibus_addr;
    logic        ibus_data_ok;
    logic [31:0] ibus_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;

    modport master (
        output ibus_req,
        output ibus_addr,
        output inst_valid,
        output inst,
        output inst_pc,
        output inst_fault,
        input  ibus_data_ok,
        input  ibus_data,
        input  redirect_valid,
        input  redirect_pc,
        input  stall
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  inst_fault,
        output ibus_data_ok,
        output ibus_data,
        output redirect_valid,
        output redirect_pc,
        output stall
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues one ibus request per PC and holds the
// fetched instruction for the F/D register. Optional FETCH_MISALIGN_CHK_EN adds a misaligned-PC fault path.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_pc;
    logic [63:0] r_pend_pc;
    logic [63:0] r_inst_pc;
    logic [31:0] r_inst;
    logic [63:0] w_pc_next;
    logic [63:0] w_pend_pc_next;
    logic [31:0] w_inst_next;
    logic        w_capture;
    logic        w_misalign;
    logic        w_ibus_req;
    logic        w_inst_valid;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    logic r_inst_fault;

    assign w_misalign  = (r_pc[1:0] != 2'b00);
    assign w_inst_next = w_misalign ? NOP_INST : bus.ibus_data;
`else
    assign w_misalign  = 1'b0;
    assign w_inst_next = bus.ibus_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirect wins over everything; an outstanding request is never withdrawn,
    // so a redirect without a same-cycle response parks the target in pend_pc.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_REQ: begin
                if (bus.redirect_valid) begin
                    w_state_next = (bus.ibus_data_ok || w_misalign) ? ST_REQ : ST_DRAIN;
                end else if (w_misalign || bus.ibus_data_ok) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.redirect_valid || !bus.stall) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (bus.ibus_data_ok) begin
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_REQ;
        endcase
    end

    always_comb begin
        w_pc_next      = r_pc;
        w_pend_pc_next = r_pend_pc;
        w_capture      = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (bus.redirect_valid) begin
                    if (bus.ibus_data_ok || w_misalign) begin
                        w_pc_next = bus.redirect_pc;
                    end else begin
                        w_pend_pc_next = bus.redirect_pc;
                    end
                end else if (w_misalign || bus.ibus_data_ok) begin
                    w_capture = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.redirect_valid) begin
                    w_pc_next = bus.redirect_pc;
                end else if (!bus.stall) begin
                    w_pc_next = r_pc + 64'd4;
                end
            end
            ST_DRAIN: begin
                if (bus.ibus_data_ok) begin
                    w_pc_next = bus.redirect_valid ? bus.redirect_pc : r_pend_pc;
                end else if (bus.redirect_valid) begin
                    w_pend_pc_next = bus.redirect_pc;
                end
            end
            default: begin
                w_pc_next = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_pend_pc <= 64'd0;
            r_inst    <= 32'd0;
            r_inst_pc <= 64'd0;
        end else begin
            r_pc      <= w_pc_next;
            r_pend_pc <= w_pend_pc_next;
            if (w_capture) begin
                r_inst    <= w_inst_next;
                r_inst_pc <= r_pc;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inst_fault <= 1'b0;
        end else if (w_capture) begin
            r_inst_fault <= w_misalign;
        end else if (w_state_next != ST_HOLD) begin
            r_inst_fault <= 1'b0;
        end
    end

    assign bus.inst_fault = r_inst_fault;
`else
    assign bus.inst_fault = 1'b0;
`endif

    always_comb begin
        w_ibus_req   = 1'b0;
        w_inst_valid = 1'b0;
        case (r_state)
            ST_REQ:   w_ibus_req   = !w_misalign;
            ST_HOLD:  w_inst_valid = 1'b1;
            ST_DRAIN: w_ibus_req   = 1'b1;
            default: begin
                w_ibus_req   = 1'b0;
                w_inst_valid = 1'b0;
            end
        endcase
    end

    assign bus.ibus_req   = w_ibus_req;
    assign bus.ibus_addr  = r_pc;
    assign bus.inst_valid = w_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed steps from the feature list, then a randomized
// run against a PC-stream reference model and a behavioural ibus responder.
module tb_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0003;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] prev_addr;
        logic        prev_hold;
        logic        busy;
        int          cnt;
        int          accepted;
        logic        ok;
        logic        rv;
        logic        st;
        logic [63:0] rpc;

        reset              = 1'b0;
        bus.ibus_data_ok   = 1'b0;
        bus.ibus_data      = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.stall          = 1'b0;
        tick;
        tick;
        chk("rst_inst_valid", bus.inst_valid, 64'd0);
        chk("rst_inst", bus.inst, 64'd0);
        chk("rst_inst_pc", bus.inst_pc, 64'd0);
        chk("rst_inst_fault", bus.inst_fault, 64'd0);

        // zero-wait response right after reset release
        reset = 1'b1;
        chk("t1_req", bus.ibus_req, 64'd1);
        chk("t1_addr", bus.ibus_addr, RESET_PC);
        bus.ibus_data_ok = 1'b1;
        bus.ibus_data    = 32'h0000_0093;
        tick;
        bus.ibus_data_ok = 1'b0;
        chk("t1_valid", bus.inst_valid, 64'd1);
        chk("t1_inst", bus.inst, 64'h93);
        chk("t1_inst_pc", bus.inst_pc, RESET_PC);
        chk("t1_hold_req", bus.ibus_req, 64'd0);
        tick;
        chk("t1_next_req", bus.ibus_req, 64'd1);
        chk("t1_next_addr", bus.ibus_addr, RESET_PC + 64'd4);
        chk("t1_next_valid", bus.inst_valid, 64'd0);

        // stall holds the instruction
        bus.ibus_data_ok = 1'b1;
        bus.ibus_data    = 32'h0010_0113;
        tick;
        bus.ibus_data_ok = 1'b0;
        bus.stall        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_valid", bus.inst_valid, 64'd1);
            chk("t2_stall_inst", bus.inst, 64'h0010_0113);
            chk("t2_stall_pc", bus.inst_pc, RESET_PC + 64'd4);
            chk("t2_stall_req", bus.ibus_req, 64'd0);
            tick;
        end
        bus.stall = 1'b0;
        chk("t2_last_valid", bus.inst_valid, 64'd1);
        tick;
        chk("t2_resume_req", bus.ibus_req, 64'd1);
        chk("t2_resume_addr", bus.ibus_addr, RESET_PC + 64'd8);

        // slow bus, redirect while outstanding
        tick;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = RESET_PC + 64'h100;
        tick;
        bus.redirect_valid = 1'b0;
        chk("t3_drain_req", bus.ibus_req, 64'd1);
        chk("t3_drain_addr", bus.ibus_addr, RESET_PC + 64'd8);
        chk("t3_drain_valid", bus.inst_valid, 64'd0);
        tick;
        chk("t3_drain_addr2", bus.ibus_addr, RESET_PC + 64'd8);
        bus.ibus_data_ok = 1'b1;
        bus.ibus_data    = 32'hDEAD_BEEF;
        tick;
        bus.ibus_data_ok = 1'b0;
        chk("t3_discard_valid", bus.inst_valid, 64'd0);
        chk("t3_new_req", bus.ibus_req, 64'd1);
        chk("t3_new_addr", bus.ibus_addr, RESET_PC + 64'h100);

        // several redirects while draining: only the last one counts
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = RESET_PC + 64'h300;
        tick;
        bus.redirect_pc    = RESET_PC + 64'h100;
        chk("t4_drain_addr", bus.ibus_addr, RESET_PC + 64'h100);
        tick;
        bus.redirect_pc    = RESET_PC + 64'h200;
        tick;
        bus.redirect_valid = 1'b0;
        bus.ibus_data_ok   = 1'b1;
        bus.ibus_data      = 32'h0BAD_0BAD;
        tick;
        bus.ibus_data_ok = 1'b0;
        chk("t4_last_redirect_addr", bus.ibus_addr, RESET_PC + 64'h200);
        chk("t4_last_redirect_req", bus.ibus_req, 64'd1);
        chk("t4_valid", bus.inst_valid, 64'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = RESET_PC + 64'h400;
        bus.ibus_data_ok   = 1'b1;
        tick;
        bus.redirect_valid = 1'b0;
        bus.ibus_data_ok   = 1'b0;
        chk("t4_simul_valid", bus.inst_valid, 64'd0);
        chk("t4_simul_req", bus.ibus_req, 64'd1);
        chk("t4_simul_addr", bus.ibus_addr, RESET_PC + 64'h400);

        // redirect in HOLD under stall drops the instruction
        bus.ibus_data_ok = 1'b1;
        bus.ibus_data    = 32'h00A0_0513;
        tick;
        bus.ibus_data_ok = 1'b0;
        chk("t5_hold_valid", bus.inst_valid, 64'd1);
        chk("t5_hold_pc", bus.inst_pc, RESET_PC + 64'h400);
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = RESET_PC + 64'h500;
        tick;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("t5_drop_valid", bus.inst_valid, 64'd0);
        chk("t5_redir_req", bus.ibus_req, 64'd1);
        chk("t5_redir_addr", bus.ibus_addr, RESET_PC + 64'h500);

        // misaligned redirect target
        bus.ibus_data_ok = 1'b1;
        bus.ibus_data    = 32'h0000_0013;
        tick;
        bus.ibus_data_ok   = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = RESET_PC + 64'h102;
        tick;
        bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_mis_req", bus.ibus_req, 64'd0);
        chk("t6_mis_valid", bus.inst_valid, 64'd0);
        tick;
        chk("t6_mis_inst", bus.inst, 64'h13);
`else
        chk("t6_mis_req", bus.ibus_req, 64'd1);
        chk("t6_mis_addr", bus.ibus_addr, RESET_PC + 64'h102);
        bus.ibus_data_ok = 1'b1;
        bus.ibus_data    = 32'h1234_5677;
        tick;
        bus.ibus_data_ok = 1'b0;
        chk("t6_mis_inst", bus.inst, 64'h1234_5677);
`endif
        chk("t6_mis_valid_hold", bus.inst_valid, 64'd1);
        chk("t6_mis_pc", bus.inst_pc, RESET_PC + 64'h102);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_mis_fault", bus.inst_fault, 64'd1);
`else
        chk("t6_mis_fault", bus.inst_fault, 64'd0);
`endif
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = RESET_PC + 64'h1000;
        tick;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("t6_fault_clear", bus.inst_fault, 64'd0);
        chk("t6_realign_addr", bus.ibus_addr, RESET_PC + 64'h1000);

        // randomized run against the PC-stream model
        exp_pc    = RESET_PC + 64'h1000;
        prev_hold = 1'b0;
        prev_addr = 64'd0;
        busy      = 1'b0;
        cnt       = 0;
        accepted  = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_hold) begin
                chk("rnd_req_held", bus.ibus_req, 64'd1);
                chk("rnd_addr_held", bus.ibus_addr, prev_addr);
            end
            chk("rnd_req_valid_excl", bus.inst_valid & bus.ibus_req, 64'd0);
            if (bus.inst_valid) begin
                chk("rnd_inst_pc", bus.inst_pc, exp_pc);
                chk("rnd_inst", bus.inst, mem_word(exp_pc));
            end
            if (!bus.ibus_req) begin
                busy = 1'b0;
            end else if (!busy) begin
                busy = 1'b1;
                cnt  = int'($urandom_range(0, 3));
            end
            ok  = bus.ibus_req && busy && (cnt == 0);
            st  = ($urandom_range(0, 2) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = RESET_PC + (64'($urandom_range(0, 1023)) << 2);
            bus.ibus_data_ok   = ok;
            bus.ibus_data      = mem_word(bus.ibus_addr);
            bus.stall          = st;
            bus.redirect_valid = rv;
            bus.redirect_pc    = rpc;
            if (rv) begin
                exp_pc = rpc;
            end else if (bus.inst_valid && !st) begin
                exp_pc = exp_pc + 64'd4;
                accepted++;
            end
            if (busy) begin
                if (ok) busy = 1'b0;
                else    cnt--;
            end
            prev_hold = bus.ibus_req && !ok;
            prev_addr = bus.ibus_addr;
            tick;
        end
        chk("rnd_progress", 64'(accepted > 100), 64'd1);

        // reset asserted mid-run takes effect without a clock edge
        bus.ibus_data_ok   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", bus.inst_valid, 64'd0);
        chk("arst_inst_pc", bus.inst_pc, 64'd0);
        chk("arst_inst", bus.inst, 64'd0);
        chk("arst_addr", bus.ibus_addr, RESET_PC);
        tick;
        reset = 1'b1;
        tick;
        chk("arst_release_req", bus.ibus_req, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
